// File: rtl/if_fetch_if.sv
// Fetch-stage bundle: decode redirect, instruction-memory req/ack port and if_id head.
// Latency: none, wiring only.
// Backpressure: stall_i from the if_id register, mem_ack_i from instruction memory.
interface if_fetch_if;
   logic        jump_i;
   logic [31:0] jump_addr_i;
   logic        stall_i;
   logic        mem_req_o;
   logic [31:0] mem_addr_o;
   logic        mem_ack_i;
   logic [31:0] mem_data_i;
   logic        inst_valid_o;
   logic [31:0] pc_o;
   logic [31:0] inst_o;

   // the fetch stage itself
   modport master (
      input  jump_i, jump_addr_i, stall_i, mem_ack_i, mem_data_i,
      output mem_req_o, mem_addr_o, inst_valid_o, pc_o, inst_o
   );

   // decode, memory and if_id side
   modport slave (
      output jump_i, jump_addr_i, stall_i, mem_ack_i, mem_data_i,
      input  mem_req_o, mem_addr_o, inst_valid_o, pc_o, inst_o
   );
endinterface

// File: rtl/if_fetch.sv
// Instruction fetch: owns the fetch PC, issues word requests, queues results in a small FIFO.
// Latency: request one cycle after reset/redirect/room; head valid one cycle after mem_ack_i.
// Backpressure: stall_i holds the head; fetch pauses while queued + outstanding fills DEPTH.
module if_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic      clk,
   input  logic      rst,
   if_fetch_if.master io_bus
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   // S_DROP keeps the bus request alive after a redirect but throws its data away
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DROP = 2'd2
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [31:0]   r_fetch_pc;
   logic [31:0]   r_req_addr;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt_nxt;
   logic [AW-1:0] r_rd_ptr;
   logic [AW-1:0] r_wr_ptr;
   logic [31:0]   r_pc_mem   [DEPTH];
   logic [31:0]   r_inst_mem [DEPTH];
   logic          w_pop;
   logic          w_push;
   logic          w_room;
   logic          w_issue;

   // FIFO occupancy bookkeeping; a redirect blocks both push and pop
   always_comb begin
      w_pop     = (r_cnt != '0) & ~io_bus.stall_i & ~io_bus.jump_i;
      w_push    = (r_state == S_WAIT) & io_bus.mem_ack_i & ~io_bus.jump_i;
      w_cnt_nxt = r_cnt + CW'(w_push) - CW'(w_pop);
      w_room    = (w_cnt_nxt < DEPTH_C);
   end

   // next state and request issue; room is judged on next-cycle occupancy
   always_comb begin
      w_state_nxt = r_state;
      w_issue     = 1'b0;
      if (io_bus.jump_i) begin
         if (r_state != S_IDLE) begin
            w_state_nxt = io_bus.mem_ack_i ? S_IDLE : S_DROP;
         end
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_room) begin
                  w_state_nxt = S_WAIT;
                  w_issue     = 1'b1;
               end
            end
            S_WAIT: begin
               if (io_bus.mem_ack_i) begin
                  if (w_room) begin
                     w_issue = 1'b1;
                  end else begin
                     w_state_nxt = S_IDLE;
                  end
               end
            end
            S_DROP: begin
               if (io_bus.mem_ack_i) begin
                  w_state_nxt = S_IDLE;
               end
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   // control state: FSM, fetch PC, request address, FIFO count and pointers
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state    <= S_IDLE;
         r_fetch_pc <= RESET_PC;
         r_req_addr <= '0;
         r_cnt      <= '0;
         r_rd_ptr   <= '0;
         r_wr_ptr   <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (io_bus.jump_i) begin
            r_cnt      <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_fetch_pc <= io_bus.jump_addr_i & 32'hFFFF_FFFC;
         end else begin
            r_cnt <= w_cnt_nxt;
            if (w_push) begin
               r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
               r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_issue) begin
               r_req_addr <= r_fetch_pc;
               r_fetch_pc <= r_fetch_pc + 32'd4;
            end
         end
      end
   end

   // FIFO storage; contents are meaningless unless covered by r_cnt, so no reset
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_pc_mem[r_wr_ptr]   <= r_req_addr;
         r_inst_mem[r_wr_ptr] <= io_bus.mem_data_i;
      end
   end

   assign io_bus.mem_req_o    = (r_state != S_IDLE);
   assign io_bus.mem_addr_o   = (r_state != S_IDLE) ? r_req_addr : 32'h0;
   assign io_bus.inst_valid_o = (r_cnt != '0);
   assign io_bus.pc_o         = (r_cnt != '0) ? r_pc_mem[r_rd_ptr]   : 32'h0;
   assign io_bus.inst_o       = (r_cnt != '0) ? r_inst_mem[r_rd_ptr] : 32'h0;
endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed redirect/stall/reset scenarios against a queue-based model.
// Latency: memory responder acks after a programmable number of wait cycles.
// Backpressure: stall_i driven directly by the stimulus.
module tb_if_fetch;
   localparam logic [31:0] RPC   = 32'h0000_0100;
   localparam logic [31:0] RPC2  = 32'hFFFF_FFF8;
   localparam int          DEPTH = 2;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } ent_t;

   logic clk;
   logic rst;

   if_fetch_if bus();
   if_fetch_if bus2();

   if_fetch #(.RESET_PC(RPC),  .DEPTH(DEPTH)) u_dut  (.clk(clk), .rst(rst), .io_bus(bus));
   if_fetch #(.RESET_PC(RPC2), .DEPTH(DEPTH)) u_dut2 (.clk(clk), .rst(rst), .io_bus(bus2));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] f(input logic [31:0] a);
      return a ^ 32'hA5A5_5A5A;
   endfunction

   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   int   to_cnt = 0;
   bit   chk_en = 1'b0;
   bit   done   = 1'b0;
   int   nAB = 0, nC = 0, nD = 0, nE = 0;
   logic [31:0] sn [string];
   ent_t pop_log [$];
   logic [31:0] mlog2 [$];

   // memory responder control
   bit          mem_auto = 1'b1;
   int          mem_lat  = 0;
   logic        man_ack  = 1'b0;
   logic [31:0] man_data = 32'h0;
   int          wait_cnt = 0;

   // main-instance memory: acks after mem_lat waiting cycles, or replays manual values
   always @(posedge clk) begin
      #2;
      if (mem_auto) begin
         if (bus.mem_req_o === 1'b1) begin
            if (wait_cnt >= mem_lat) begin
               bus.mem_ack_i  = 1'b1;
               bus.mem_data_i = f(bus.mem_addr_o);
               wait_cnt = 0;
            end else begin
               bus.mem_ack_i = 1'b0;
               wait_cnt++;
            end
         end else begin
            bus.mem_ack_i = 1'b0;
            wait_cnt = 0;
         end
      end else begin
         bus.mem_ack_i  = man_ack;
         bus.mem_data_i = man_data;
         wait_cnt = 0;
      end
   end

   // second instance: zero-wait memory, logs every accepted address
   always @(posedge clk) begin
      #2;
      bus2.mem_ack_i  = (bus2.mem_req_o === 1'b1);
      bus2.mem_data_i = f(bus2.mem_addr_o);
      if (bus2.mem_req_o === 1'b1) mlog2.push_back(bus2.mem_addr_o);
   end

   initial begin
      bus2.jump_i = 1'b0;
      bus2.jump_addr_i = 32'h0;
      bus2.stall_i = 1'b0;
   end

   // behavioural model: queued instructions plus at most one outstanding fetch
   ent_t        mq [$];
   logic        m_out  = 1'b0;
   logic        m_keep = 1'b0;
   logic [31:0] m_addr = 32'h0;
   logic [31:0] m_pc   = RPC;

   always @(posedge clk) begin
      bit   was_out;
      bit   acked;
      bit   kept;
      ent_t e;
      if (rst !== 1'b1) begin
         mq.delete();
         m_out = 1'b0;
         m_keep = 1'b0;
         m_addr = 32'h0;
         m_pc = RPC;
      end else if (bus.jump_i) begin
         mq.delete();
         m_pc = bus.jump_addr_i & 32'hFFFF_FFFC;
         if (m_out && !bus.mem_ack_i) m_keep = 1'b0;
         else m_out = 1'b0;
      end else begin
         was_out = m_out;
         acked   = m_out && bus.mem_ack_i;
         kept    = m_keep;
         if (mq.size() != 0 && !bus.stall_i) mq.delete(0);
         if (acked) begin
            if (kept) begin
               e.pc = m_addr;
               e.inst = bus.mem_data_i;
               mq.push_back(e);
            end
            m_out = 1'b0;
         end
         if ((!was_out || (acked && kept)) && mq.size() < DEPTH) begin
            m_out = 1'b1;
            m_keep = 1'b1;
            m_addr = m_pc;
            m_pc = m_pc + 32'd4;
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d: got %h want %h", nm, cyc, act, exp);
      end
   endtask

   function automatic ent_t lp(input int i);
      if (i >= 0 && i < pop_log.size()) return pop_log[i];
      return '0;
   endfunction

   function automatic logic [31:0] ml2(input int i);
      if (i >= 0 && i < mlog2.size()) return mlog2[i];
      return 32'hXXXX_XXXX;
   endfunction

   task automatic final_checks();
      int junk;
      chk("timeouts", 32'(to_cnt), 32'd0);
      chk("ab_pop_count_ok", 32'(nAB >= 9), 32'd1);
      for (int i = 0; i < nAB; i++) begin
         chk("ab_pop_pc", lp(i).pc, RPC + 32'(4 * i));
         chk("ab_pop_inst", lp(i).inst, f(RPC + 32'(4 * i)));
      end
      chk("stall_req",   sn["b1_req"],  32'd0);
      chk("stall_vld",   sn["b1_vld"],  32'd1);
      chk("stall_pc",    sn["b1_pc"],   32'h118);
      chk("stall_inst",  sn["b1_inst"], f(32'h118));
      chk("stall_pc2",   sn["b2_pc"],   32'h118);
      chk("stall_req2",  sn["b2_req"],  32'd0);
      chk("drain0_pc",   sn["d0_pc"],   32'h11C);
      chk("drain1_pc",   sn["d1_pc"],   32'h120);
      chk("drain2_pc",   sn["d2_pc"],   32'h124);
      chk("drain0_vld",  sn["d0_vld"],  32'd1);
      chk("drain1_vld",  sn["d1_vld"],  32'd1);
      chk("drain2_vld",  sn["d2_vld"],  32'd1);
      chk("jmp_vld_after", sn["c_vld"], 32'd0);
      chk("jmp_first_pc",   lp(nC).pc,     32'h2000);
      chk("jmp_first_inst", lp(nC).inst,   f(32'h2000));
      chk("jmp_second_pc",  lp(nC + 1).pc, 32'h2004);
      chk("full_vld",    sn["dpre_vld"], 32'd1);
      chk("full_req",    sn["dpre_req"], 32'd0);
      chk("jack_vld",    sn["dj1_vld"],  32'd0);
      chk("jack_req",    sn["dj1_req"],  32'd0);
      chk("jack_req2",   sn["dj2_req"],  32'd1);
      chk("jack_addr2",  sn["dj2_addr"], 32'h3000);
      chk("jack_pop_pc",   lp(nD).pc,   32'h3000);
      chk("jack_pop_inst", lp(nD).inst, f(32'h3000));
      chk("rst_vld",     sn["e_vld"],  32'd0);
      chk("rst_req",     sn["e_req"],  32'd1);
      chk("rst_addr",    sn["e_addr"], RPC);
      chk("rst_pop_pc",   lp(nE).pc,   RPC);
      chk("rst_pop_inst", lp(nE).inst, f(RPC));
      junk = 0;
      foreach (pop_log[i])
         if (pop_log[i].inst == 32'hDEAD_BEEF || pop_log[i].inst == 32'hBADC_0DE0) junk++;
      chk("dropped_data_seen", 32'(junk), 32'd0);
      chk("wrap_addr0", ml2(0), 32'hFFFF_FFF8);
      chk("wrap_addr1", ml2(1), 32'hFFFF_FFFC);
      chk("wrap_addr2", ml2(2), 32'h0000_0000);
   endtask

   // per-cycle compare against the model, pop logging, end-of-run checks and watchdog
   always @(negedge clk) begin
      cyc++;
      if (chk_en) begin
         chk("mem_req_o",    32'(bus.mem_req_o),    32'(m_out));
         chk("mem_addr_o",   bus.mem_addr_o,        m_out ? m_addr : 32'h0);
         chk("inst_valid_o", 32'(bus.inst_valid_o), 32'(mq.size() != 0));
         chk("pc_o",         bus.pc_o,              (mq.size() != 0) ? mq[0].pc   : 32'h0);
         chk("inst_o",       bus.inst_o,            (mq.size() != 0) ? mq[0].inst : 32'h0);
         if (rst === 1'b1 && bus.inst_valid_o === 1'b1 && !bus.stall_i && !bus.jump_i)
            pop_log.push_back('{pc: bus.pc_o, inst: bus.inst_o});
      end
      if (done) begin
         final_checks();
         $display("test done: total=%0d bad=%0d", total, bad);
         $finish;
      end else if (cyc > 3000) begin
         bad++;
         $display("FAIL watchdog: got cycle %0d want done before 3000", cyc);
         $display("test done: total=%0d bad=%0d", total, bad);
         $finish;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // wait until a request has been pending for exactly one unanswered cycle
   task automatic wait_pending();
      bit found;
      found = 1'b0;
      for (int k = 0; k < 60 && !found; k++) begin
         @(negedge clk);
         if (bus.mem_req_o === 1'b1 && wait_cnt == 1) found = 1'b1;
      end
      if (!found) to_cnt++;
   endtask

   initial begin
      rst = 1'b0;
      bus.jump_i = 1'b0;
      bus.jump_addr_i = 32'h0;
      bus.stall_i = 1'b0;
      tick();
      chk_en = 1'b1;
      tick();
      rst = 1'b1;

      // streaming with zero-wait memory
      repeat (8) tick();

      // five stall cycles: FIFO fills, request drops, head frozen, then drains
      bus.stall_i = 1'b1;
      tick(); tick();
      @(negedge clk);
      sn["b1_req"] = 32'(bus.mem_req_o);
      sn["b1_vld"] = 32'(bus.inst_valid_o);
      sn["b1_pc"] = bus.pc_o;
      sn["b1_inst"] = bus.inst_o;
      tick(); tick();
      @(negedge clk);
      sn["b2_pc"] = bus.pc_o;
      sn["b2_req"] = 32'(bus.mem_req_o);
      tick();
      bus.stall_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         @(negedge clk);
         sn[$sformatf("d%0d_pc", i)] = bus.pc_o;
         sn[$sformatf("d%0d_vld", i)] = 32'(bus.inst_valid_o);
      end
      repeat (3) tick();
      nAB = pop_log.size();

      // redirect to an unaligned target while a slow fetch is outstanding
      mem_lat = 3;
      wait_pending();
      tick();
      bus.jump_i = 1'b1;
      bus.jump_addr_i = 32'h0000_2003;
      tick();
      bus.jump_i = 1'b0;
      nC = pop_log.size();
      @(negedge clk);
      sn["c_vld"] = 32'(bus.inst_valid_o);
      repeat (16) tick();

      // redirect coinciding with a stray ack while stalled on a full FIFO
      bus.stall_i = 1'b1;
      mem_lat = 0;
      repeat (8) tick();
      mem_auto = 1'b0;
      man_ack = 1'b0;
      tick();
      @(negedge clk);
      sn["dpre_vld"] = 32'(bus.inst_valid_o);
      sn["dpre_req"] = 32'(bus.mem_req_o);
      tick();
      bus.jump_i = 1'b1;
      bus.jump_addr_i = 32'h0000_3000;
      man_ack = 1'b1;
      man_data = 32'hDEAD_BEEF;
      tick();
      bus.jump_i = 1'b0;
      man_ack = 1'b0;
      @(negedge clk);
      sn["dj1_vld"] = 32'(bus.inst_valid_o);
      sn["dj1_req"] = 32'(bus.mem_req_o);
      tick();
      @(negedge clk);
      sn["dj2_req"] = 32'(bus.mem_req_o);
      sn["dj2_addr"] = bus.mem_addr_o;
      tick();
      bus.stall_i = 1'b0;
      mem_auto = 1'b1;
      nD = pop_log.size();
      repeat (6) tick();

      // reset in the middle of a request, late ack lands on the release edge
      mem_lat = 3;
      wait_pending();
      tick();
      rst = 1'b0;
      mem_auto = 1'b0;
      man_ack = 1'b0;
      tick(); tick();
      rst = 1'b1;
      man_ack = 1'b1;
      man_data = 32'hBADC_0DE0;
      tick();
      man_ack = 1'b0;
      @(negedge clk);
      sn["e_vld"] = 32'(bus.inst_valid_o);
      sn["e_req"] = 32'(bus.mem_req_o);
      sn["e_addr"] = bus.mem_addr_o;
      tick();
      mem_lat = 0;
      mem_auto = 1'b1;
      nE = pop_log.size();
      repeat (6) tick();
      done = 1'b1;
   end
endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
Instruction-fetch stage: the receiving end of the decode stage's jump_o/jump_addr_o redirect interface. It owns the fetch PC and issues word requests on a req/ack instruction-memory port. Fetched words go into a small FIFO, and the FIFO head is presented to the if_id register as pc_o/inst_o with valid/stall flow control. A redirect flushes the FIFO and any in-flight fetch, and fetching restarts at the jump target.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
DEPTH, 2, fetch FIFO entries (power of two, >=2)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-low reset (sampled on clk rising edge; 0 = reset)
jump_i  input  1  redirect request from decode
jump_addr_i  input  32  redirect target; bits [1:0] ignored (treated as 0)
stall_i  input  1  downstream cannot accept this cycle
mem_req_o  output  1  fetch request outstanding
mem_addr_o  output  32  fetch word address, bits [1:0] always 0
mem_ack_i  input  1  request complete; mem_data_i valid this cycle
mem_data_i  input  32  fetched instruction word
inst_valid_o  output  1  FIFO head valid
pc_o  output  32  PC of head instruction
inst_o  output  32  head instruction word

Behaviour:
- Reset (rst==0 at edge): fetch_pc=RESET_PC, state=S_IDLE, FIFO count=0, rd/wr pointers=0. Outputs: mem_req_o=0, mem_addr_o=0, inst_valid_o=0, pc_o=0, inst_o=0.
- Reset takes priority over everything. A reset during an outstanding request abandons it; any later mem_ack_i in S_IDLE is ignored.
- States:
  - S_IDLE: no request outstanding.
  - S_WAIT: request outstanding, result is kept.
  - S_DROP: request outstanding, result is discarded.
- Outputs per state:
  - mem_req_o = (state!=S_IDLE).
  - mem_addr_o = the registered req_addr; it is held stable while mem_req_o=1 and is 0 in S_IDLE.
  - A request is never withdrawn before mem_ack_i.
- pop = inst_valid_o & ~stall_i & ~jump_i.
- push = (state==S_WAIT) & mem_ack_i & ~jump_i.
- cnt_next = count + push - pop.
- Priority each cycle: reset > jump_i > normal.
- jump_i=1:
  - FIFO flushed (count=0, pointers reset) and fetch_pc=jump_addr_i&~3.
  - S_IDLE -> S_IDLE.
  - S_WAIT or S_DROP with mem_ack_i=1 -> S_IDLE; the acked data is dropped.
  - S_WAIT or S_DROP with mem_ack_i=0 -> S_DROP.
  - jump_i overrides stall_i.
- Normal operation:
  - S_IDLE: if cnt_next<DEPTH, go to S_WAIT with req_addr=fetch_pc and fetch_pc+=4.
  - S_WAIT, mem_ack_i=1: push {req_addr, mem_data_i}. If cnt_next<DEPTH, stay in S_WAIT with req_addr=fetch_pc and fetch_pc+=4 (back-to-back requests); otherwise go to S_IDLE.
  - S_WAIT, mem_ack_i=0: hold.
  - S_DROP, mem_ack_i=1: go to S_IDLE.
  - S_DROP, mem_ack_i=0: hold.
- Invariant: count + outstanding <= DEPTH, so a push never hits a full FIFO.
- Output path:
  - inst_valid_o = (count!=0).
  - pc_o/inst_o = FIFO head (combinational from storage), 0 when empty.
  - While stall_i=1 the head is held stable.
- Latency:
  - Reset released at cycle 0: mem_req_o=1 at cycle 1 with addr RESET_PC.
  - Ack at cycle k: inst_valid_o=1 at cycle k+1.
  - Jump at cycle j with no request outstanding: new request at cycle j+1; first valid output 1 cycle after its ack.
  - Jump at cycle j with a request outstanding: the new request is issued the cycle after the dropped request is acked.
- Arithmetic: fetch_pc wraps mod 2^32 (0xFFFF_FFFC+4 = 0).
- Simultaneous push and pop on a full FIFO are both allowed; count is unchanged.
- mem_ack_i while in S_IDLE is ignored.

Test Plan:
1. Reset release, RESET_PC=0x100, memory acks every request in its first cycle, stall_i=0 -> requests at 0x100, 0x104, 0x108 on consecutive cycles; pc_o sequence 0x100, 0x104, 0x108, each with the matching mem_data_i.
2. stall_i=1 held for 5 cycles, DEPTH=2 -> count reaches 2, mem_req_o falls to 0, pc_o/inst_o stable; on stall release the two queued instructions drain in order with no gap and fetch resumes at the next address.
3. jump_i=1 with jump_addr_i=0x2003 while a request to 0x108 is outstanding, ack 3 cycles later -> mem_addr_o holds 0x108 until ack; the 0x108 data is never presented; next request to 0x2000; inst_valid_o=0 from the cycle after the jump until the 0x2000 data arrives.
4. jump_i coincident with mem_ack_i and stall_i=1 while the FIFO holds 2 entries -> FIFO empty next cycle, acked data dropped, request to the target issued the following cycle.
5. RESET_PC=0xFFFF_FFF8 -> fetch addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
6. rst=0 asserted mid-request, then memory acks after reset release -> that ack is ignored (no valid output); fetch restarts at RESET_PC.
